// File: rtl/pla_eval.sv
// Programmable AND/OR array evaluator: a writable product-term table feeding a
// two-stage pipeline (term vector, then OR plane) with ready/valid handshakes.
module pla_eval #(
   parameter int unsigned N_IN   = 7,
   parameter int unsigned N_OUT  = 4,
   parameter int unsigned N_TERM = 16,
   localparam int unsigned AW    = (N_TERM > 1) ? $clog2(N_TERM) : 1,
   localparam int unsigned W     = 2 * N_IN + N_OUT + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [W-1:0]     cfg_data,
   input  logic             cfg_commit,
   input  logic             cfg_start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_OUT-1:0] out_data,
   output logic             cfg_mode,
   output logic             cfg_err
);

   typedef enum logic [1:0] {S_CFG, S_RUN, S_DRAIN} state_t;

   state_t              state;
   logic [W-1:0]        term_tbl [N_TERM];
   logic                s1_valid;
   logic [N_TERM-1:0]   s1_terms;
   logic [N_TERM-1:0]   terms_c;
   logic [N_OUT-1:0]    or_c;
   logic                stall;
   logic                accept;
   logic                addr_ok;
   logic                we_ok;

   assign stall    = out_valid && !out_ready;
   assign in_ready = (state == S_RUN) && !stall;
   assign accept   = in_valid && in_ready;
   assign addr_ok  = {1'b0, cfg_addr} < (AW + 1)'(N_TERM);
   assign we_ok    = cfg_we && (state == S_CFG) && addr_ok;

   // AND plane: a term is live when enabled and every selected literal holds.
   always_comb begin
      terms_c = '0;
      for (int t = 0; t < int'(N_TERM); t++) begin
         terms_c[t] = term_tbl[t][W-1] &&
                      (&((~term_tbl[t][0 +: N_IN]    |  in_data) &
                         (~term_tbl[t][N_IN +: N_IN] | ~in_data)));
      end
   end

   // OR plane over the registered term vector.
   always_comb begin
      or_c = '0;
      for (int t = 0; t < int'(N_TERM); t++) begin
         if (s1_terms[t]) begin
            or_c = or_c | term_tbl[t][2 * N_IN +: N_OUT];
         end
      end
   end

   // Mode FSM plus the sticky illegal-access flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_CFG;
         cfg_mode <= 1'b1;
         cfg_err  <= 1'b0;
      end else begin
         if (cfg_we && !((state == S_CFG) && addr_ok)) begin
            cfg_err <= 1'b1;
         end
         case (state)
            S_CFG: begin
               if (cfg_commit) begin
                  state    <= S_RUN;
                  cfg_mode <= 1'b0;
               end
            end
            S_RUN: begin
               if (cfg_start) begin
                  state    <= S_DRAIN;
                  cfg_mode <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (!s1_valid && !out_valid) begin
                  state <= S_CFG;
               end
            end
            default: begin
               state    <= S_CFG;
               cfg_mode <= 1'b1;
            end
         endcase
      end
   end

   // Term table; writes only land in CFG, so RUN and DRAIN see a frozen table.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int t = 0; t < int'(N_TERM); t++) begin
            term_tbl[t] <= '0;
         end
      end else begin
         for (int t = 0; t < int'(N_TERM); t++) begin
            if (we_ok && (cfg_addr == AW'(t))) begin
               term_tbl[t] <= cfg_data;
            end
         end
      end
   end

   // Both stages advance together; a stalled output freezes the whole pipe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_terms  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (!stall) begin
         s1_valid  <= accept;
         if (accept) begin
            s1_terms <= terms_c;
         end
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= or_c;
         end
      end
   end

endmodule
